pos_decoder: RTL and testbench

POS_DECODER -- requirements
Module: pos_decoder

---
 rtl/pos_decoder.sv | 140 ++++++++++++++
 tb/tb_pos_decoder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pos_decoder.sv
// pos_decoder: collects 3-bit positions into an 8-bit frame vector,
// then presents the vector with its popcount and a duplicate flag
// until the downstream side takes it.

module pos_decoder (
  input  logic       clk,
  input  logic       areset_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_pos,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_vec,
  output logic [3:0] out_count,
  output logic       out_dup
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } pos_state_t;

  pos_state_t r_state;
  pos_state_t w_stateNext;

  logic [7:0] r_acc;
  logic [7:0] w_accNext;
  logic       r_dup;
  logic       w_dupNext;

  logic [7:0] r_outVec;
  logic [7:0] w_outVecNext;
  logic [3:0] r_outCount;
  logic [3:0] w_outCountNext;
  logic       r_outDup;
  logic       w_outDupNext;

  // Goes high on the first edge after reset release, so in_ready stays low
  // through reset and comes up one edge later.
  logic       r_live;

  logic       w_accept;
  logic [7:0] w_decode;
  logic [7:0] w_merged;
  logic       w_repeat;
  logic [3:0] w_mergedCount;

  // Counts set bits in a byte; result fits 0..8 without wrapping.
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

  assign in_ready  = r_live && (r_state != HOLD);
  assign out_valid = (r_state == HOLD);
  assign out_vec   = r_outVec;
  assign out_count = r_outCount;
  assign out_dup   = r_outDup;

  assign w_accept      = in_valid && in_ready;
  assign w_decode      = 8'b0000_0001 << in_pos;
  assign w_merged      = r_acc | w_decode;
  assign w_repeat      = |(r_acc & w_decode);
  assign w_mergedCount = popcount8(w_merged);

  // Releases input acceptance one edge after reset deasserts.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_live <= 1'b0;
    end else begin
      r_live <= 1'b1;
    end
  end

  // State, accumulator and held-frame registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      r_state    <= IDLE;
      r_acc      <= 8'h00;
      r_dup      <= 1'b0;
      r_outVec   <= 8'h00;
      r_outCount <= 4'd0;
      r_outDup   <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_acc      <= w_accNext;
      r_dup      <= w_dupNext;
      r_outVec   <= w_outVecNext;
      r_outCount <= w_outCountNext;
      r_outDup   <= w_outDupNext;
    end
  end

  // Next-state logic: accumulate while open, snapshot on the last position,
  // and hold the snapshot until downstream consumes it.
  always_comb begin
    w_stateNext    = r_state;
    w_accNext      = r_acc;
    w_dupNext      = r_dup;
    w_outVecNext   = r_outVec;
    w_outCountNext = r_outCount;
    w_outDupNext   = r_outDup;

    case (r_state)
      IDLE, ACCUM: begin
        if (w_accept) begin
          if (in_last) begin
            w_outVecNext   = w_merged;
            w_outCountNext = w_mergedCount;
            w_outDupNext   = r_dup | w_repeat;
            w_accNext      = 8'h00;
            w_dupNext      = 1'b0;
            w_stateNext    = HOLD;
          end else begin
            w_accNext   = w_merged;
            w_dupNext   = r_dup | w_repeat;
            w_stateNext = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_accNext   = 8'h00;
        w_dupNext   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pos_decoder.sv
// tb_pos_decoder: directed frames with hand-computed expectations.

module tb_pos_decoder;

  logic       clk;
  logic       areset_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_pos;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_vec;
  logic [3:0] out_count;
  logic       out_dup;

  int testsRun;
  int testsFailed;

  pos_decoder dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_vec   (out_vec),
    .out_count (out_count),
    .out_dup   (out_dup)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one position for one cycle; block must be ready.
  task automatic applyStimulus(input logic [2:0] pos, input logic last);
    in_valid = 1'b1;
    in_pos   = pos;
    in_last  = last;
    checkOutput("inReadyBeforeAccept", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Check the held frame right after the last-accept edge.
  task automatic checkFrame(input string tag, input logic [7:0] vec,
                            input logic [3:0] cnt, input logic dup);
    checkOutput({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
    checkOutput({tag, ".vec"}, {24'b0, out_vec}, {24'b0, vec});
    checkOutput({tag, ".count"}, {28'b0, out_count}, {28'b0, cnt});
    checkOutput({tag, ".dup"}, {31'b0, out_dup}, {31'b0, dup});
  endtask

  logic [7:0] capVec [2];
  logic [3:0] capCnt [2];
  int         capIdx;
  int         bubbles;
  int         sent;
  logic [2:0] seqPos [4];
  logic       seqLast[4];

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    areset_n    = 1'b0;
    in_valid    = 1'b0;
    in_pos      = 3'd0;
    in_last     = 1'b0;
    out_ready   = 1'b1;

    // Reset state
    repeat (3) tick();
    checkOutput("rst.inReady", {31'b0, in_ready}, 32'd0);
    checkOutput("rst.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst.outVec", {24'b0, out_vec}, 32'd0);
    checkOutput("rst.outCount", {28'b0, out_count}, 32'd0);
    checkOutput("rst.outDup", {31'b0, out_dup}, 32'd0);
    areset_n = 1'b1;
    #1;
    checkOutput("rel.inReadyPreEdge", {31'b0, in_ready}, 32'd0);
    tick();
    checkOutput("rel.inReady", {31'b0, in_ready}, 32'd1);

    // Single frame 0,3,7: valid for exactly one cycle
    applyStimulus(3'd0, 1'b0);
    checkOutput("f1.noEarlyValid", {31'b0, out_valid}, 32'd0);
    applyStimulus(3'd3, 1'b0);
    applyStimulus(3'd7, 1'b1);
    checkFrame("f1", 8'h89, 4'd3, 1'b0);
    checkOutput("f1.inReadyHold", {31'b0, in_ready}, 32'd0);
    tick();
    checkOutput("f1.validDrop", {31'b0, out_valid}, 32'd0);
    checkOutput("f1.inReadyBack", {31'b0, in_ready}, 32'd1);
    checkOutput("f1.vecKept", {24'b0, out_vec}, 32'h89);

    // Duplicate 2,2,5 then clean single-position frame 1
    applyStimulus(3'd2, 1'b0);
    applyStimulus(3'd2, 1'b0);
    applyStimulus(3'd5, 1'b1);
    checkFrame("dup", 8'h24, 4'd2, 1'b1);
    tick();
    applyStimulus(3'd1, 1'b1);
    checkFrame("afterDup", 8'h02, 4'd1, 1'b0);
    tick();

    // Backpressure: frame 4 held for 5 cycles, stall-time inputs ignored
    out_ready = 1'b0;
    applyStimulus(3'd4, 1'b1);
    checkFrame("bp", 8'h10, 4'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_pos   = 3'(i);
      in_last  = 1'b1;
      tick();
      checkOutput("bp.valid", {31'b0, out_valid}, 32'd1);
      checkOutput("bp.vec", {24'b0, out_vec}, 32'h10);
      checkOutput("bp.inReady", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    checkOutput("bp.release", {31'b0, out_valid}, 32'd0);
    applyStimulus(3'd6, 1'b1);
    checkFrame("bpNext", 8'h40, 4'd1, 1'b0);
    tick();

    // Full frame 7 down to 0
    for (int p = 7; p >= 0; p--) begin
      applyStimulus(3'(p), (p == 0));
    end
    checkFrame("full", 8'hFF, 4'd8, 1'b0);
    tick();

    // Reset mid-frame discards partial positions
    applyStimulus(3'd1, 1'b0);
    applyStimulus(3'd6, 1'b0);
    areset_n = 1'b0;
    #1;
    checkOutput("mid.inReady", {31'b0, in_ready}, 32'd0);
    checkOutput("mid.outValid", {31'b0, out_valid}, 32'd0);
    checkOutput("mid.outVec", {24'b0, out_vec}, 32'd0);
    tick();
    areset_n = 1'b1;
    tick();
    applyStimulus(3'd0, 1'b1);
    checkFrame("mid", 8'h01, 4'd1, 1'b0);
    tick();

    // Back-to-back frames {3,5} and {0,1} with in_valid held high
    seqPos  = '{3'd3, 3'd5, 3'd0, 3'd1};
    seqLast = '{1'b0, 1'b1, 1'b0, 1'b1};
    sent    = 0;
    capIdx  = 0;
    bubbles = 0;
    for (int cyc = 0; cyc < 20 && capIdx < 2; cyc++) begin
      if (out_valid) begin
        capVec[capIdx] = out_vec;
        capCnt[capIdx] = out_count;
        capIdx++;
      end
      if (capIdx >= 2) break;
      in_valid = 1'b1;
      in_pos   = seqPos[sent < 4 ? sent : 3];
      in_last  = seqLast[sent < 4 ? sent : 3];
      if (!in_ready && sent > 0 && sent < 4) bubbles++;
      if (sent >= 4) in_valid = 1'b0;
      if (in_ready && sent < 4) sent++;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("b2b.framesSeen", capIdx, 32'd2);
    checkOutput("b2b.bubbles", bubbles, 32'd1);
    if (capIdx >= 2) begin
      checkOutput("b2b.vecA", {24'b0, capVec[0]}, 32'h28);
      checkOutput("b2b.cntA", {28'b0, capCnt[0]}, 32'd2);
      checkOutput("b2b.vecB", {24'b0, capVec[1]}, 32'h03);
      checkOutput("b2b.cntB", {28'b0, capCnt[1]}, 32'd2);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
